fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit_next_pc.sv | 40 ++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - Decoder branch codes (BR_*) driven on the fetch_unit branch input.
//   - NOP_INSTR: word presented to the decoder whenever no fetched
//     instruction is executing.
//   - fetch_state_e: fetch sequencer state encoding.
package fetch_unit_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_NZ   = 3'b001;
    localparam logic [2:0] BR_Z    = 3'b010;
    localparam logic [2:0] BR_JAL  = 3'b011;
    localparam logic [2:0] BR_JALR = 3'b100;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_EXEC = 2'b10,
        ST_TRAP = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and memory.
//   iaddr       byte address of the requested word
//   imem_req    read request, qualifies iaddr
//   imem_rdata  returned instruction word
//   imem_valid  imem_rdata valid this cycle
// master: fetch unit side; slave: memory side.
interface fetch_unit_if;

    logic [31:0] iaddr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output iaddr,
        output imem_req,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  iaddr,
        input  imem_req,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// fetch_next_pc: combinational next-PC selection and alignment check.
//   pc          current instruction address
//   branch      decoder branch code (BR_*)
//   zero        ALU zero flag
//   imm         sign-extended immediate
//   jalr_target rs1+imm from the ALU
//   next_pc     address of the following instruction (modulo 2^32)
//   misalign    next_pc is not word aligned
module fetch_next_pc (
    input  logic [31:0] pc,
    input  logic [2:0]  branch,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc,
    output logic        misalign
);
    import fetch_unit_pkg::*;

    logic [31:0] pc_seq;
    logic [31:0] pc_rel;

    assign pc_seq = pc + 32'd4;
    assign pc_rel = pc + imm;

    always_comb begin
        next_pc = pc_seq;
        case (branch)
            BR_Z:    if (zero)  next_pc = pc_rel;
            BR_NZ:   if (!zero) next_pc = pc_rel;
            BR_JAL:  next_pc = pc_rel;
            // jalr clears bit 0 of the target; bit 1 can still misalign
            BR_JALR: next_pc = jalr_target & 32'hFFFF_FFFE;
            default: next_pc = pc_seq;
        endcase
    end

    assign misalign = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch sequencer with PC, instruction latch, misalignment
// trap flag and retired-instruction counter.
//   clk, reset     single clock, synchronous active-high reset
//   imem           instruction-memory bus (master side)
//   idata          instruction presented to the decoder
//   instr_valid    idata is executing this cycle
//   branch, zero, imm, jalr_target   decoder/ALU inputs for next PC
//   pc, pc_plus4   current instruction address and its link value
//   misalign       sticky misaligned control-transfer flag
//   instret        executed instruction count
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | reading imem at pc, waiting for imem_valid
// EXEC  | latched word executes for one cycle, pc advances at its end
// TRAP  | misaligned target seen, halted until reset
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    output logic [31:0]        idata,
    output logic               instr_valid,
    input  logic [2:0]         branch,
    input  logic               zero,
    input  logic [31:0]        imm,
    input  logic [31:0]        jalr_target,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               misalign,
    output logic [31:0]        instret
);
    import fetch_unit_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  instret_q, instret_d;

    logic [31:0]  next_pc;
    logic         next_misalign;

    fetch_next_pc u_next_pc (
        .pc          (pc_q),
        .branch      (branch),
        .zero        (zero),
        .imm         (imm),
        .jalr_target (jalr_target),
        .next_pc     (next_pc),
        .misalign    (next_misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            misalign_q <= 1'b0;
            instret_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
            instret_q  <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        instret_d  = instret_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem.imem_valid) begin
                    instr_d = imem.imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (next_misalign) begin
                    misalign_d = 1'b1;
                    state_d    = ST_TRAP;
                end else begin
                    pc_d      = next_pc;
                    instret_d = instret_q + 32'd1;
                    state_d   = ST_REQ;
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem.iaddr    = pc_q;
    assign imem.imem_req = (state_q == ST_REQ);
    assign instr_valid   = (state_q == ST_EXEC);
    assign idata         = (state_q == ST_EXEC) ? instr_q : NOP_INSTR;
    assign pc            = pc_q;
    assign pc_plus4      = pc_q + 32'd4;
    assign misalign      = misalign_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] idata;
    logic        instr_valid;
    logic [2:0]  branch;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] jalr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit_if imem_bus ();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_bus),
        .idata       (idata),
        .instr_valid (instr_valid),
        .branch      (branch),
        .zero        (zero),
        .imm         (imm),
        .jalr_target (jalr_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Ends at a negedge in IDLE, reset just released.
    task automatic apply_reset();
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        branch = BR_NONE; zero = 1'b0; imm = 32'h0; jalr_target = 32'h0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    // Called at a negedge in REQ; returns at the negedge after the EXEC cycle.
    task automatic exec_one(input logic [2:0] br, input logic z,
                            input logic [31:0] im, input logic [31:0] jt);
        branch = br; zero = z; imm = im; jalr_target = jt;
        imem_bus.imem_rdata = 32'h0000_0033 ^ im;
        imem_bus.imem_valid = 1'b1;
        @(negedge clk);
        imem_bus.imem_valid = 1'b0;
        @(negedge clk);
        branch = BR_NONE;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", imem_bus.imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", instr_valid); end
        n_checks++; if (idata !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_idata: got %h exp 00000013", idata); end
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", pc); end
        n_checks++; if (imem_bus.iaddr !== 32'h0) begin n_fail++; $display("FAIL rst_iaddr: got %h exp 0", imem_bus.iaddr); end
        n_checks++; if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc_plus4: got %h exp 4", pc_plus4); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b exp 0", misalign); end
        n_checks++; if (instret !== 32'h0) begin n_fail++; $display("FAIL rst_instret: got %0d exp 0", instret); end
    endtask

    task automatic test_sequential();
        logic [31:0] word;
        apply_reset();
        imem_bus.imem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word = 32'hA000_0000 | i;
            imem_bus.imem_rdata = word;
            @(negedge clk);
            n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d]: got %b exp 1", i, imem_bus.imem_req); end
            n_checks++; if (imem_bus.iaddr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_iaddr[%0d]: got %h exp %h", i, imem_bus.iaddr, 32'(4 * i)); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_nvalid[%0d]: got %b exp 0", i, instr_valid); end
            @(negedge clk);
            n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b exp 1", i, instr_valid); end
            n_checks++; if (idata !== word) begin n_fail++; $display("FAIL seq_idata[%0d]: got %h exp %h", i, idata, word); end
            n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_exec_req[%0d]: got %b exp 0", i, imem_bus.imem_req); end
        end
        @(negedge clk);
        n_checks++; if (instret !== 32'd3) begin n_fail++; $display("FAIL seq_instret: got %0d exp 3", instret); end
        n_checks++; if (imem_bus.iaddr !== 32'hC) begin n_fail++; $display("FAIL seq_iaddr_end: got %h exp c", imem_bus.iaddr); end
        imem_bus.imem_valid = 1'b0;
    endtask

    task automatic test_branch();
        apply_reset();
        @(negedge clk);
        exec_one(BR_JAL, 1'b0, 32'h100, 32'h0);
        n_checks++; if (imem_bus.iaddr !== 32'h100) begin n_fail++; $display("FAIL br_jal: got %h exp 100", imem_bus.iaddr); end
        exec_one(BR_Z, 1'b1, 32'hFFFF_FFF0, 32'h0);
        n_checks++; if (imem_bus.iaddr !== 32'h0F0) begin n_fail++; $display("FAIL br_z_taken: got %h exp f0", imem_bus.iaddr); end
        exec_one(BR_JAL, 1'b0, 32'h10, 32'h0);
        exec_one(BR_Z, 1'b0, 32'hFFFF_FFF0, 32'h0);
        n_checks++; if (imem_bus.iaddr !== 32'h104) begin n_fail++; $display("FAIL br_z_not: got %h exp 104", imem_bus.iaddr); end
        exec_one(BR_NZ, 1'b1, 32'h20, 32'h0);
        n_checks++; if (imem_bus.iaddr !== 32'h108) begin n_fail++; $display("FAIL br_nz_not: got %h exp 108", imem_bus.iaddr); end
        exec_one(BR_NZ, 1'b0, 32'h20, 32'h0);
        n_checks++; if (imem_bus.iaddr !== 32'h128) begin n_fail++; $display("FAIL br_nz_taken: got %h exp 128", imem_bus.iaddr); end
        exec_one(3'b101, 1'b1, 32'h40, 32'h0);
        n_checks++; if (imem_bus.iaddr !== 32'h12C) begin n_fail++; $display("FAIL br_code5: got %h exp 12c", imem_bus.iaddr); end
        n_checks++; if (instret !== 32'd7) begin n_fail++; $display("FAIL br_instret: got %0d exp 7", instret); end
    endtask

    task automatic test_jalr();
        apply_reset();
        @(negedge clk);
        exec_one(BR_JAL, 1'b0, 32'h200, 32'h0);
        branch = BR_JALR; jalr_target = 32'h0000_0345;
        imem_bus.imem_rdata = 32'h0000_8067; imem_bus.imem_valid = 1'b1;
        @(negedge clk);
        imem_bus.imem_valid = 1'b0;
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL jalr_exec: got %b exp 1", instr_valid); end
        n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL jalr_pc: got %h exp 200", pc); end
        n_checks++; if (pc_plus4 !== 32'h204) begin n_fail++; $display("FAIL jalr_pc_plus4: got %h exp 204", pc_plus4); end
        @(negedge clk);
        branch = BR_NONE;
        n_checks++; if (imem_bus.iaddr !== 32'h344) begin n_fail++; $display("FAIL jalr_target: got %h exp 344", imem_bus.iaddr); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL jalr_misalign: got %b exp 0", misalign); end
        exec_one(BR_JAL, 1'b0, 32'hFFFF_FCBC, 32'h0);
        n_checks++; if (imem_bus.iaddr !== 32'h0) begin n_fail++; $display("FAIL wrap_iaddr: got %h exp 0", imem_bus.iaddr); end
        n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req: got %b exp 1", imem_bus.imem_req); end
        n_checks++; if (instret !== 32'd3) begin n_fail++; $display("FAIL wrap_instret: got %0d exp 3", instret); end
    endtask

    task automatic test_trap();
        apply_reset();
        @(negedge clk);
        exec_one(BR_JAL, 1'b0, 32'h2, 32'h0);
        n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL trap_misalign: got %b exp 1", misalign); end
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL trap_pc: got %h exp 0", pc); end
        n_checks++; if (instret !== 32'd0) begin n_fail++; $display("FAIL trap_instret: got %0d exp 0", instret); end
        imem_bus.imem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL trap_req[%0d]: got %b exp 0", i, imem_bus.imem_req); end
            n_checks++; if (instr_valid !== 1'b0 || idata !== 32'h0000_0013) begin n_fail++; $display("FAIL trap_idle[%0d]: got %b/%h exp 0/00000013", i, instr_valid, idata); end
            @(negedge clk);
        end
        n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL trap_sticky: got %b exp 1", misalign); end
        apply_reset();
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL trap_clear: got %b exp 0", misalign); end
    endtask

    task automatic test_wait_states();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req[%0d]: got %b exp 1", k, imem_bus.imem_req); end
            n_checks++; if (idata !== 32'h0000_0013 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_nop[%0d]: got %h/%b exp 00000013/0", k, idata, instr_valid); end
            if (k == 3) begin
                imem_bus.imem_rdata = 32'h1234_5678;
                imem_bus.imem_valid = 1'b1;
            end
        end
        @(negedge clk);
        imem_bus.imem_valid = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || idata !== 32'h1234_5678) begin n_fail++; $display("FAIL wait_exec: got %b/%h exp 1/12345678", instr_valid, idata); end
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL wait_exec_req: got %b exp 0", imem_bus.imem_req); end
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0 || imem_bus.iaddr !== 32'h4) begin n_fail++; $display("FAIL wait_after: got %b/%h exp 0/4", instr_valid, imem_bus.iaddr); end
        n_checks++; if (instret !== 32'd1) begin n_fail++; $display("FAIL wait_instret: got %0d exp 1", instret); end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        @(negedge clk);
        exec_one(BR_NONE, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF; imem_bus.imem_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL abort_req_pc: got %h exp 0", pc); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL abort_req_valid: got %b exp 0", instr_valid); end
        n_checks++; if (instret !== 32'd0) begin n_fail++; $display("FAIL abort_req_instret: got %0d exp 0", instret); end
        n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL abort_req_req: got %b exp 0", imem_bus.imem_req); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_bus.imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL late_valid: got req %b valid %b exp 1/0", imem_bus.imem_req, instr_valid); end
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL abort_exec_enter: got %b exp 1", instr_valid); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; imem_bus.imem_valid = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL abort_exec: got %b/%h exp 0/0", instr_valid, pc); end
        n_checks++; if (instret !== 32'd0) begin n_fail++; $display("FAIL abort_exec_instret: got %0d exp 0", instret); end
    endtask

    initial begin
        reset = 1'b1;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        branch = BR_NONE; zero = 1'b0; imm = 32'h0; jalr_target = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jalr();
        test_trap();
        test_wait_states();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
